// File: rtl/gat_pkg.sv
// Shared types and constants for the GAT layer scheduler: stage ids, FSM states
// and the bit offsets of the packed status word.
package gat_pkg;

    localparam int NUM_STAGES = 4;

    typedef enum logic [1:0] {
        STG_SPMM,
        STG_DMVM,
        STG_SM,
        STG_AGGR
    } stage_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE,
        ERROR
    } sched_state_e;

    localparam int STATUS_ISSUED   = 0;
    localparam int STATUS_INFLIGHT = 4;
    localparam int STATUS_PERR     = 8;
    localparam int STATUS_TIMEOUT  = 12;
    localparam int STATUS_DONE_CNT = 16;

endpackage

// File: rtl/gat_stage_tracker.sv
// Book-keeping for one compute stage: issue/done counters, in-flight flag,
// registered go pulse with its sub-graph index, watchdog and protocol-error flag.
module gat_stage_tracker #(
    parameter int SG_W    = 16,
    parameter int TIMEOUT = 1048576
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            issue,
    input  logic            done_pulse,
    output logic            go,
    output logic [SG_W-1:0] idx,
    output logic [SG_W-1:0] iss_cnt,
    output logic [SG_W-1:0] done_cnt,
    output logic            inflight,
    output logic            issued_ever,
    output logic            perr,
    output logic            timeout
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd;

    always_ff @(posedge clk) begin
        if (rst) begin
            go          <= 1'b0;
            idx         <= '0;
            iss_cnt     <= '0;
            done_cnt    <= '0;
            inflight    <= 1'b0;
            issued_ever <= 1'b0;
            perr        <= 1'b0;
            timeout     <= 1'b0;
            wd          <= '0;
        end else begin
            go <= issue;
            if (clr) begin
                iss_cnt     <= '0;
                done_cnt    <= '0;
                inflight    <= 1'b0;
                issued_ever <= 1'b0;
                perr        <= 1'b0;
                timeout     <= 1'b0;
                wd          <= '0;
            end else begin
                // issue only fires when idle, so it never collides with an accepted done
                if (issue) begin
                    idx         <= iss_cnt;
                    iss_cnt     <= iss_cnt + SG_W'(1);
                    inflight    <= 1'b1;
                    issued_ever <= 1'b1;
                    wd          <= '0;
                end else if (done_pulse && inflight) begin
                    inflight <= 1'b0;
                    done_cnt <= done_cnt + SG_W'(1);
                    wd       <= '0;
                end else if (inflight && !timeout) begin
                    if (wd == WD_W'(TIMEOUT - 1)) timeout <= 1'b1;
                    wd <= wd + WD_W'(1);
                end
                if (done_pulse && !inflight) perr <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/gat_stage_scheduler.sv
// Layer sequencer: issues SPMM -> DMVM -> SOFTMAX -> AGGR over N sub-graphs,
// overlapping stages up to BUF_DEPTH buffers, with watchdog and status readout.
module gat_stage_scheduler
    import gat_pkg::*;
#(
    parameter int SG_W      = 16,
    parameter int BUF_DEPTH = 2,
    parameter int TIMEOUT   = 1048576,
    parameter int CYC_W     = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start_i,
    input  logic [SG_W-1:0]                  num_subgraph_i,
    output logic [NUM_STAGES-1:0]            stage_go_o,
    output logic [NUM_STAGES-1:0][SG_W-1:0]  stage_idx_o,
    input  logic [NUM_STAGES-1:0]            stage_done_i,
    output logic                             busy_o,
    output logic                             done_o,
    output logic                             err_o,
    output logic [31:0]                      status_o,
    output logic [CYC_W-1:0]                 cycle_cnt_o,
    output sched_state_e                     dbg_state_o
);

    // Stage handshake: stage_go_o[s] is a one-cycle pulse with stage_idx_o[s] valid
    // on it; the stage answers later with a one-cycle stage_done_i[s]. One job per stage.

    sched_state_e          state, state_nxt;
    logic [SG_W-1:0]       num_q;
    logic                  clr, run_ok, aggr_last;
    logic [NUM_STAGES-1:0] issue, inflight, issued, perr, timeout;
    logic [SG_W-1:0]       iss_cnt  [NUM_STAGES];
    logic [SG_W-1:0]       done_cnt [NUM_STAGES];

    assign run_ok    = (state == RUN) && !(|timeout);
    // Look ahead on the final AGGR done so done_o lands on the very next cycle
    assign aggr_last = stage_done_i[NUM_STAGES-1] && inflight[NUM_STAGES-1] &&
                       (done_cnt[NUM_STAGES-1] + SG_W'(1) == num_q);

    for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
        logic up_ok, down_ok;
        if (s == int'(STG_SPMM)) begin : g_first
            assign up_ok = 1'b1;
        end else begin : g_up
            assign up_ok = done_cnt[s-1] > iss_cnt[s];
        end
        if (s == int'(STG_AGGR)) begin : g_last
            assign down_ok = 1'b1;
        end else begin : g_down
            assign down_ok = (iss_cnt[s] - done_cnt[s+1]) < SG_W'(BUF_DEPTH);
        end
        assign issue[s] = run_ok && !inflight[s] && (iss_cnt[s] < num_q) && up_ok && down_ok;

        gat_stage_tracker #(
            .SG_W    (SG_W),
            .TIMEOUT (TIMEOUT)
        ) u_trk (
            .clk         (clk),
            .rst         (rst),
            .clr         (clr),
            .issue       (issue[s]),
            .done_pulse  (stage_done_i[s]),
            .go          (stage_go_o[s]),
            .idx         (stage_idx_o[s]),
            .iss_cnt     (iss_cnt[s]),
            .done_cnt    (done_cnt[s]),
            .inflight    (inflight[s]),
            .issued_ever (issued[s]),
            .perr        (perr[s]),
            .timeout     (timeout[s])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            num_q       <= '0;
            cycle_cnt_o <= '0;
        end else begin
            state <= state_nxt;
            if (clr) begin
                num_q       <= num_subgraph_i;
                cycle_cnt_o <= '0;
            end else if (state == RUN && cycle_cnt_o != '1) begin
                cycle_cnt_o <= cycle_cnt_o + CYC_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        clr       = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    clr       = 1'b1;
                    state_nxt = (num_subgraph_i == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (|timeout)      state_nxt = ERROR;
                else if (aggr_last) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            ERROR:   state_nxt = ERROR;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        status_o = '0;
        status_o[STATUS_ISSUED   +: NUM_STAGES] = issued;
        status_o[STATUS_INFLIGHT +: NUM_STAGES] = inflight;
        status_o[STATUS_PERR     +: NUM_STAGES] = perr;
        status_o[STATUS_TIMEOUT  +: NUM_STAGES] = timeout;
        status_o[STATUS_DONE_CNT +: 16]         = 16'(done_cnt[NUM_STAGES-1]);
    end

    assign busy_o      = (state == RUN) || (state == ERROR);
    assign done_o      = (state == DONE);
    assign err_o       = |timeout;
    assign dbg_state_o = state;

endmodule

// File: tb/tb_gat_stage_scheduler.sv
// Directed bench for gat_stage_scheduler: instance a (ping-pong, short watchdog)
// and instance b (single buffer), each with an automatic stage responder.
module tb_gat_stage_scheduler;
    import gat_pkg::*;

    localparam int SG_W = 16;
    localparam int LAT  = 5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- instance a ----------------
    logic                              start_a, err_a, busy_a, donep_a;
    logic [SG_W-1:0]                   num_a;
    logic [NUM_STAGES-1:0]             go_a, done_a, rdone_a, inj_a, resp_en_a;
    logic [NUM_STAGES-1:0][SG_W-1:0]   idx_a;
    logic [31:0]                       status_a, cyc_a;
    sched_state_e                      dbg_a;
    int                                rcnt_a [NUM_STAGES];

    gat_stage_scheduler #(.SG_W(SG_W), .BUF_DEPTH(2), .TIMEOUT(64), .CYC_W(32)) dut_a (
        .clk(clk), .rst(rst), .start_i(start_a), .num_subgraph_i(num_a),
        .stage_go_o(go_a), .stage_idx_o(idx_a), .stage_done_i(done_a),
        .busy_o(busy_a), .done_o(donep_a), .err_o(err_a), .status_o(status_a),
        .cycle_cnt_o(cyc_a), .dbg_state_o(dbg_a)
    );

    // ---------------- instance b ----------------
    logic                              start_b, err_b, busy_b, donep_b;
    logic [SG_W-1:0]                   num_b;
    logic [NUM_STAGES-1:0]             go_b, done_b;
    logic [NUM_STAGES-1:0][SG_W-1:0]   idx_b;
    logic [31:0]                       status_b, cyc_b;
    sched_state_e                      dbg_b;
    int                                rcnt_b [NUM_STAGES];

    gat_stage_scheduler #(.SG_W(SG_W), .BUF_DEPTH(1), .TIMEOUT(64), .CYC_W(32)) dut_b (
        .clk(clk), .rst(rst), .start_i(start_b), .num_subgraph_i(num_b),
        .stage_go_o(go_b), .stage_idx_o(idx_b), .stage_done_i(done_b),
        .busy_o(busy_b), .done_o(donep_b), .err_o(err_b), .status_o(status_b),
        .cycle_cnt_o(cyc_b), .dbg_state_o(dbg_b)
    );

    // ---------------- stage responders: done LAT cycles after go ----------------
    always @(negedge clk) begin
        for (int s = 0; s < NUM_STAGES; s++) begin
            rdone_a[s] = 1'b0;
            if (rst) rcnt_a[s] = 0;
            else if (go_a[s] && resp_en_a[s]) rcnt_a[s] = LAT;
            else if (rcnt_a[s] != 0) begin
                rcnt_a[s] = rcnt_a[s] - 1;
                if (rcnt_a[s] == 0) rdone_a[s] = 1'b1;
            end
            done_b[s] = 1'b0;
            if (rst) rcnt_b[s] = 0;
            else if (go_b[s]) rcnt_b[s] = LAT;
            else if (rcnt_b[s] != 0) begin
                rcnt_b[s] = rcnt_b[s] - 1;
                if (rcnt_b[s] == 0) done_b[s] = 1'b1;
            end
        end
    end
    assign done_a = rdone_a | inj_a;

    // ---------------- scoreboards / monitors ----------------
    logic [SG_W-1:0] exp_q_a [NUM_STAGES][$];
    logic [SG_W-1:0] exp_q_b [NUM_STAGES][$];
    bit   chk_idx_a = 1'b1;
    int   gocnt_a [NUM_STAGES];
    int   gocnt_b [NUM_STAGES];
    int   donep_cnt_a, done_cyc_a, first_go0_a, go1_cyc_a, to_cyc_a, go_after_err_a;
    int   donep_cnt_b, spmm1_cyc_b, viol_b;
    bit   overlap_a, busy_seen_a;
    logic [31:0] to_status_a;

    always @(negedge clk) begin
        if (go_a != '0 && err_a) go_after_err_a++;
        if (busy_a) busy_seen_a = 1'b1;
        for (int s = 0; s < NUM_STAGES; s++) begin
            if (go_a[s]) begin
                gocnt_a[s]++;
                if (s == 0 && first_go0_a < 0) first_go0_a = cyc;
                if (s == 1 && go1_cyc_a < 0) go1_cyc_a = cyc;
                if (s == 0 && status_a[5]) overlap_a = 1'b1;
                if (chk_idx_a) begin
                    if (exp_q_a[s].size() == 0) check("a_go_extra", 32'(s), 32'hDEAD);
                    else check($sformatf("a_idx_s%0d", s), 32'(idx_a[s]), 32'(exp_q_a[s].pop_front()));
                end
            end
            if (go_b[s]) begin
                gocnt_b[s]++;
                if (s == 0 && idx_b[0] == 16'd1) spmm1_cyc_b = cyc;
                if (exp_q_b[s].size() == 0) check("b_go_extra", 32'(s), 32'hDEAD);
                else check($sformatf("b_idx_s%0d", s), 32'(idx_b[s]), 32'(exp_q_b[s].pop_front()));
            end
        end
        if ((status_b[6:4] & status_b[7:5]) != 3'b000) viol_b++;
        if (donep_a) begin donep_cnt_a++; done_cyc_a = cyc; end
        if (donep_b) donep_cnt_b++;
        if (status_a[13] && to_cyc_a < 0) begin to_cyc_a = cyc; to_status_a = status_a; end
    end

    // ---------------- driver tasks ----------------
    int t0_a, t0_b;

    task automatic start_layer_a(input int n, input logic [3:0] inj);
        for (int s = 0; s < NUM_STAGES; s++) begin
            exp_q_a[s].delete();
            for (int i = 0; i < n; i++) exp_q_a[s].push_back(SG_W'(i));
            gocnt_a[s] = 0;
        end
        donep_cnt_a = 0; done_cyc_a = -1; first_go0_a = -1; go1_cyc_a = -1;
        to_cyc_a = -1; go_after_err_a = 0; overlap_a = 0; busy_seen_a = 0;
        @(posedge clk); #1;
        start_a = 1'b1; num_a = SG_W'(n); t0_a = cyc;
        @(posedge clk); #1;
        start_a = 1'b0; inj_a = inj;
        @(posedge clk); #1;
        inj_a = '0;
    endtask

    task automatic wait_done_a(input int budget);
        for (int i = 0; i < budget && donep_cnt_a == 0; i++) @(posedge clk);
        check("a_layer_done_in_budget", 32'(donep_cnt_a != 0), 32'd1);
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
    endtask

    task automatic check_idle_a(input string tag);
        check({tag, "_go"},     32'(go_a), 32'd0);
        check({tag, "_idx"},    32'(|idx_a), 32'd0);
        check({tag, "_busy"},   32'(busy_a), 32'd0);
        check({tag, "_done"},   32'(donep_a), 32'd0);
        check({tag, "_err"},    32'(err_a), 32'd0);
        check({tag, "_status"}, status_a, 32'd0);
        check({tag, "_cycles"}, cyc_a, 32'd0);
        check({tag, "_state"},  32'(dbg_a), 32'(IDLE));
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start_a = 0; num_a = '0; inj_a = '0; resp_en_a = 4'hF;
        start_b = 0; num_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_a("reset_a");
        check("reset_b_status", status_b, 32'd0);
        check("reset_b_busy", 32'(busy_b), 32'd0);
        rst = 1'b0;

        // N=3, ping-pong buffers
        start_layer_a(3, 4'b0000);
        wait_done_a(200);
        check("t1_first_go_latency", 32'(first_go0_a - t0_a), 32'd2);
        check("t1_done_latency", 32'(done_cyc_a - t0_a), 32'd43);
        for (int s = 0; s < NUM_STAGES; s++) begin
            check($sformatf("t1_go_count_s%0d", s), 32'(gocnt_a[s]), 32'd3);
            check($sformatf("t1_idx_left_s%0d", s), 32'(exp_q_a[s].size()), 32'd0);
        end
        check("t1_overlap", 32'(overlap_a), 32'd1);
        check("t1_done_pulses", 32'(donep_cnt_a), 32'd1);
        check("t1_status", status_a, 32'h0003_000F);
        check("t1_cycles", cyc_a, 32'd42);
        check("t1_busy_after", 32'(busy_a), 32'd0);

        // stray SM done while SM idle
        start_layer_a(2, 4'b0100);
        wait_done_a(200);
        check("t5_status", status_a, 32'h0002_040F);
        check("t5_go_count_aggr", 32'(gocnt_a[3]), 32'd2);
        check("t5_done_pulses", 32'(donep_cnt_a), 32'd1);

        // N=0
        start_layer_a(0, 4'b0000);
        wait_done_a(20);
        check("t3_done_latency", 32'(done_cyc_a - t0_a), 32'd1);
        check("t3_go_total", 32'(gocnt_a[0] + gocnt_a[1] + gocnt_a[2] + gocnt_a[3]), 32'd0);
        check("t3_busy_seen", 32'(busy_seen_a), 32'd0);
        check("t3_status", status_a, 32'd0);
        check("t3_cycles", cyc_a, 32'd0);

        // DMVM never answers: watchdog
        resp_en_a = 4'b1101;
        start_layer_a(2, 4'b0000);
        for (int i = 0; i < 300 && to_cyc_a < 0; i++) @(posedge clk);
        check("t4_timeout_seen", 32'(to_cyc_a >= 0), 32'd1);
        check("t4_timeout_delay", 32'(to_cyc_a - go1_cyc_a), 32'd64);
        check("t4_status_at_timeout", to_status_a, 32'h0000_2023);
        repeat (10) @(posedge clk);
        #1;
        check("t4_err", 32'(err_a), 32'd1);
        check("t4_busy_held", 32'(busy_a), 32'd1);
        check("t4_state", 32'(dbg_a), 32'(ERROR));
        check("t4_go_after_err", 32'(go_after_err_a), 32'd0);
        check("t4_no_done", 32'(donep_cnt_a), 32'd0);
        resp_en_a = 4'hF;
        pulse_reset();
        check_idle_a("t4_recover");

        // reset mid-run, then a fresh layer with a stray start during RUN
        chk_idx_a = 1'b0;
        start_layer_a(8, 4'b0000);
        for (int i = 0; i < 400 && status_a[31:16] != 16'd3; i++) @(posedge clk);
        check("t6_three_aggr_done", 32'(status_a[31:16]), 32'd3);
        pulse_reset();
        check_idle_a("t6_after_rst");
        @(posedge clk); #1;
        check("t6_go_stays_low", 32'(go_a), 32'd0);
        chk_idx_a = 1'b1;
        start_layer_a(1, 4'b0000);
        repeat (3) @(posedge clk);
        #1; start_a = 1'b1; num_a = 16'd5;
        @(posedge clk); #1; start_a = 1'b0;
        wait_done_a(200);
        check("t6_done_latency", 32'(done_cyc_a - t0_a), 32'd29);
        check("t6_go_count_spmm", 32'(gocnt_a[0]), 32'd1);
        check("t6_done_pulses", 32'(donep_cnt_a), 32'd1);
        check("t6_status", status_a, 32'h0001_000F);
        check("t6_cycles", cyc_a, 32'd28);

        // single buffer, N=2 on instance b
        for (int s = 0; s < NUM_STAGES; s++) begin
            for (int i = 0; i < 2; i++) exp_q_b[s].push_back(SG_W'(i));
            gocnt_b[s] = 0;
        end
        donep_cnt_b = 0; spmm1_cyc_b = -1; viol_b = 0;
        @(posedge clk); #1; start_b = 1'b1; num_b = 16'd2; t0_b = cyc;
        @(posedge clk); #1; start_b = 1'b0;
        for (int i = 0; i < 300 && donep_cnt_b == 0; i++) @(posedge clk);
        repeat (5) @(posedge clk);
        #1;
        check("t2_done_pulses", 32'(donep_cnt_b), 32'd1);
        check("t2_spmm_idx1_time", 32'(spmm1_cyc_b - t0_b), 32'd16);
        check("t2_adjacent_inflight", 32'(viol_b), 32'd0);
        for (int s = 0; s < NUM_STAGES; s++)
            check($sformatf("t2_go_count_s%0d", s), 32'(gocnt_b[s]), 32'd2);
        check("t2_status", status_b, 32'h0002_000F);
        check("t2_busy_after", 32'(busy_b), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
